reg_file_param: RTL and testbench

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_pkg.sv | 19 +
 rtl/reg_file_wdec.sv | 33 +++
 rtl/reg_file_param.sv | 130 +++++++++++++
 tb/tb_reg_file_param.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_file_pkg: shared state encoding and default sizing constants   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package reg_file_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_DEPTH    = 16;
   localparam int DEF_ZERO_REG = 0;
   localparam int DEF_BYPASS   = 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_wdec.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_file_wdec: write address / byte-enable decode to an enable     |
// | matrix (one row per entry, one bit per byte lane). Rev 1.0         |
// +--------------------------------------------------------------------+
module reg_file_wdec
   import reg_file_pkg::*;
#(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int BE_W     = DEF_DATA_W / 8,
   parameter int ADDR_W   = $clog2(DEF_DEPTH),
   parameter int ZERO_REG = DEF_ZERO_REG
) (
   input  logic                        wr_en,
   input  logic [ADDR_W-1:0]           waddr,
   input  logic [BE_W-1:0]             wbe,
   output logic                        accept,
   output logic [DEPTH-1:0][BE_W-1:0]  en
);

   logic addr_ok;

   // Entry 0 is read-only when it is hard-wired to zero.
   assign addr_ok = ({1'b0, waddr} < (ADDR_W + 1)'(DEPTH)) &&
                    !((ZERO_REG != 0) && (waddr == '0));
   assign accept  = wr_en && addr_ok;

   for (genvar i = 0; i < DEPTH; i++) begin : g_row
      assign en[i] = (accept && (waddr == ADDR_W'(i))) ? wbe : '0;
   end

endmodule
`default_nettype wire

// File: rtl/reg_file_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_file_param: 2R/1W register file with byte enables, optional    |
// | write bypass, zero register and a sweep-clear FSM. Rev 1.0         |
// +--------------------------------------------------------------------+
module reg_file_param
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ZERO_REG = DEF_ZERO_REG,
   parameter int BYPASS   = DEF_BYPASS
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          we,
   input  logic [$clog2(DEPTH)-1:0]      waddr,
   input  logic [DATA_W-1:0]             wdata,
   input  logic [DATA_W/8-1:0]           wbe,
   input  logic [$clog2(DEPTH)-1:0]      raddr_a,
   input  logic [$clog2(DEPTH)-1:0]      raddr_b,
   output logic [DATA_W-1:0]             rdata_a,
   output logic [DATA_W-1:0]             rdata_b,
   input  logic                          clr_req,
   output logic                          busy,
   output logic                          wr_err
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int BE_W   = DATA_W / 8;

   logic [DATA_W-1:0]            mem [DEPTH];
   logic [DEPTH-1:0][BE_W-1:0]   en;
   logic                         accept;
   state_t                       state;
   logic [ADDR_W-1:0]            cnt;
   logic [ADDR_W-1:0]            raddr [2];
   logic [DATA_W-1:0]            rdata [2];

   reg_file_wdec #(
      .DEPTH    (DEPTH),
      .BE_W     (BE_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_wdec (
      .wr_en  (we && !busy && !reset),
      .waddr  (waddr),
      .wbe    (wbe),
      .accept (accept),
      .en     (en)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         busy   <= 1'b0;
         wr_err <= 1'b0;
      end else begin
         wr_err <= we && !accept;
         case (state)
            IDLE: begin
               if (clr_req) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end
            end
            CLEAR: begin
               if (cnt == ADDR_W'(DEPTH - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Writes are never accepted while sweeping, so the two updates cannot collide.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            for (int b = 0; b < BE_W; b++) begin
               if (en[i][b]) mem[i][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
         if (state == CLEAR) mem[cnt] <= '0;
      end
   end

   assign raddr[0] = raddr_a;
   assign raddr[1] = raddr_b;
   assign rdata_a  = rdata[0];
   assign rdata_b  = rdata[1];

   for (genvar p = 0; p < 2; p++) begin : g_rport
      logic [DATA_W-1:0] nxt;

      // The enable row of the read address already encodes "accepted write here".
      always_comb begin
         nxt = '0;
         if (({1'b0, raddr[p]} < (ADDR_W + 1)'(DEPTH)) &&
             !((ZERO_REG != 0) && (raddr[p] == '0))) begin
            nxt = mem[raddr[p]];
            if (BYPASS != 0) begin
               for (int b = 0; b < BE_W; b++) begin
                  if (en[raddr[p]][b]) nxt[8*b +: 8] = wdata[8*b +: 8];
               end
            end
         end
      end

      always_ff @(posedge clk) begin
         if (reset) rdata[p] <= '0;
         else       rdata[p] <= nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_reg_file_param: directed self-checking bench, three parameter   |
// | sets sharing one stimulus stream. Rev 1.0                          |
// +--------------------------------------------------------------------+
module tb_reg_file_param;

   logic        clk = 1'b0;
   logic        reset, we, clr_req;
   logic [3:0]  waddr, raddr_a, raddr_b;
   logic [31:0] wdata;
   logic [3:0]  wbe;

   logic [31:0] ra_d, rb_d, ra_n, rb_n, ra_z, rb_z;
   logic        busy_d, busy_n, busy_z, err_d, err_n, err_z;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 clk = ~clk;

   reg_file_param #(.DATA_W(32), .DEPTH(16), .ZERO_REG(0), .BYPASS(1)) dut (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra_d), .rdata_b(rb_d),
      .clr_req(clr_req), .busy(busy_d), .wr_err(err_d));

   reg_file_param #(.DATA_W(32), .DEPTH(16), .ZERO_REG(0), .BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra_n), .rdata_b(rb_n),
      .clr_req(clr_req), .busy(busy_n), .wr_err(err_n));

   reg_file_param #(.DATA_W(32), .DEPTH(12), .ZERO_REG(1), .BYPASS(1)) dut_z (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra_z), .rdata_b(rb_z),
      .clr_req(clr_req), .busy(busy_z), .wr_err(err_z));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      we = 1'b1; waddr = a; wdata = d; wbe = be;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; we = 1'b0; clr_req = 1'b0;
      waddr = '0; wdata = '0; wbe = '0; raddr_a = '0; raddr_b = '0;
      tick(); tick();
      reset = 1'b0;
      check("reset_rdata_a", ra_d, 32'h0);
      check("reset_rdata_b", rb_d, 32'h0);
      check("reset_busy", {31'b0, busy_d}, 32'h0);
      check("reset_wr_err", {31'b0, err_d}, 32'h0);

      // Full-word write with read of the same address in the same cycle.
      wr(4'd5, 32'hDEADBEEF, 4'hF); raddr_a = 4'd5;
      tick();
      check("bypass_full", ra_d, 32'hDEADBEEF);
      check("nobypass_full", ra_n, 32'h0);
      we = 1'b0;
      tick();
      check("read_addr5", ra_d, 32'hDEADBEEF);
      check("read_addr5_nb", ra_n, 32'hDEADBEEF);

      // Partial byte-lane write merged with old contents.
      wr(4'd3, 32'h11223344, 4'hF);
      tick();
      wr(4'd3, 32'hAABBCCDD, 4'b0101); raddr_b = 4'd3;
      tick();
      check("bypass_merge", rb_d, 32'h11BB33DD);
      check("nobypass_old", rb_n, 32'h11223344);
      we = 1'b0;
      tick();
      check("merge_stored", rb_d, 32'h11BB33DD);
      check("merge_stored_nb", rb_n, 32'h11BB33DD);

      // Zero register and out-of-range address.
      wr(4'd0, 32'hFFFFFFFF, 4'hF); raddr_a = 4'd0;
      tick();
      check("zreg_wr_err", {31'b0, err_z}, 32'h1);
      check("zreg_no_err_default", {31'b0, err_d}, 32'h0);
      check("zreg_bypass_zero", ra_z, 32'h0);
      we = 1'b0;
      tick();
      check("zreg_read_zero", ra_z, 32'h0);
      check("addr0_normal", ra_d, 32'hFFFFFFFF);
      check("zreg_err_clears", {31'b0, err_z}, 32'h0);
      wr(4'd13, 32'h12345678, 4'hF); raddr_a = 4'd13;
      tick();
      check("oor_wr_err", {31'b0, err_z}, 32'h1);
      check("oor_bypass_zero", ra_z, 32'h0);
      check("inrange_bypass", ra_d, 32'h12345678);
      we = 1'b0;
      tick();
      check("oor_read_zero", ra_z, 32'h0);

      // Fill, then sweep-clear with a dropped write mid-sweep.
      for (int i = 0; i < 16; i++) begin
         wr(i[3:0], 32'hA5000000 | i, 4'hF);
         tick();
      end
      we = 1'b0; raddr_a = 4'd9;
      tick();
      check("fill_readback", ra_d, 32'hA5000009);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      n = 0;
      while (busy_d === 1'b1 && n < 40) begin
         if (n == 2) wr(4'd0, 32'hFFFFFFFF, 4'hF);
         else we = 1'b0;
         tick();
         n++;
         if (n == 3) check("busy_wr_err", {31'b0, err_d}, 32'h1);
      end
      we = 1'b0;
      check("busy_cycles", n, 32'd16);
      for (int i = 0; i < 16; i++) begin
         raddr_a = i[3:0];
         tick();
         check($sformatf("cleared_%0d", i), ra_d, 32'h0);
      end

      // Reset in the middle of a sweep, then a fresh sweep with a coincident write.
      wr(4'd9, 32'h99999999, 4'hF);
      tick();
      we = 1'b0; raddr_b = 4'd9;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("busy_before_abort", {31'b0, busy_d}, 32'h1);
      check("unswept_entry", rb_d, 32'h99999999);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", {31'b0, busy_d}, 32'h0);
      check("abort_rdata_b", rb_d, 32'h0);
      check("abort_wr_err", {31'b0, err_d}, 32'h0);
      tick();
      check("abort_entry9", rb_d, 32'h0);

      wr(4'd15, 32'hCAFEF00D, 4'hF); clr_req = 1'b1; raddr_a = 4'd15;
      tick();
      we = 1'b0; clr_req = 1'b0;
      n = 0;
      while (busy_d === 1'b1 && n < 40) begin
         tick();
         n++;
         if (n == 1) check("write_wins_over_clr", ra_d, 32'hCAFEF00D);
      end
      check("busy_cycles_after_reset", n, 32'd16);
      tick();
      check("entry15_swept", ra_d, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
